// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor: default widths,
// per-line update actions, counter encodings and PC field slicing.
package branch_predictor_pkg;

  localparam int unsigned DEFAULT_PC_WIDTH = 32;
  localparam int unsigned SLICE_W          = 64;

  // Action applied to the direction counter of the addressed line.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_INC,
    ACT_DEC,
    ACT_SET_MAX,
    ACT_LOAD_WT
  } upd_act_e;

  // Weakly-taken: MSB set, remaining bits clear.
  function automatic logic [SLICE_W-1:0] cnt_weak_taken(input int unsigned w);
    return SLICE_W'(64'd1 << (w - 1));
  endfunction

  // Weakly-not-taken: MSB clear, remaining bits set.
  function automatic logic [SLICE_W-1:0] cnt_weak_not_taken(input int unsigned w);
    return SLICE_W'((64'd1 << (w - 1)) - 64'd1);
  endfunction

  // Strongly-taken: all ones.
  function automatic logic [SLICE_W-1:0] cnt_strong_taken(input int unsigned w);
    return SLICE_W'((64'd1 << w) - 64'd1);
  endfunction

  // Line index: PC[idx_bits+1:2].
  function automatic logic [SLICE_W-1:0] pc_idx(input logic [SLICE_W-1:0] pc,
                                                 input int unsigned idx_bits);
    return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  // Tag: the tag_width bits directly above the index.
  function automatic logic [SLICE_W-1:0] pc_tag(input logic [SLICE_W-1:0] pc,
                                                 input int unsigned idx_bits,
                                                 input int unsigned tag_width);
    return (pc >> (idx_bits + 2)) & ((64'd1 << tag_width) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with load and set-to-max, used both for the
// per-line direction counters and for the performance counters.
module bp_sat_counter #(
  parameter int unsigned           WIDTH   = 2,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             set_max_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next value: load wins, then set-max, then saturating inc/dec.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (set_max_i) begin
      cnt_d = '1;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + WIDTH'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: zero-latency lookup for fetch,
// table training and misprediction redirect from execute, plus saturating
// performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = DEFAULT_PC_WIDTH,
  parameter int unsigned ENTRIES    = 64,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pred_PC,
  output logic                  pred_taken,
  output logic [PC_WIDTH-1:0]   pred_target,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_PC,
  input  logic                  upd_is_branch,
  input  logic                  upd_taken,
  input  logic [PC_WIDTH-1:0]   upd_target,
  input  logic                  upd_pred_taken,
  input  logic [PC_WIDTH-1:0]   upd_pred_target,
  output logic                  mispredict,
  output logic [PC_WIDTH-1:0]   redirect_PC,
  input  logic                  flush_req,
  input  logic                  perf_clear,
  output logic [PERF_WIDTH-1:0] perf_branches,
  output logic [PERF_WIDTH-1:0] perf_mispredicts
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);

  localparam logic [CNT_WIDTH-1:0] CNT_WT  = CNT_WIDTH'(cnt_weak_taken(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_WNT = CNT_WIDTH'(cnt_weak_not_taken(CNT_WIDTH));

  logic [ENTRIES-1:0]   valid_q;
  logic [ENTRIES-1:0]   valid_d;
  logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0]  target_q [ENTRIES];
  logic [CNT_WIDTH-1:0] line_cnt [ENTRIES];

  logic [IDX_BITS-1:0]  p_idx;
  logic [TAG_WIDTH-1:0] p_tag;
  logic                 p_hit;
  logic [IDX_BITS-1:0]  u_idx;
  logic [TAG_WIDTH-1:0] u_tag;
  logic                 u_hit;
  logic                 upd_en;
  logic                 tbl_wr;
  upd_act_e             act;

  assign p_idx = IDX_BITS'(pc_idx(SLICE_W'(pred_PC), IDX_BITS));
  assign p_tag = TAG_WIDTH'(pc_tag(SLICE_W'(pred_PC), IDX_BITS, TAG_WIDTH));
  assign u_idx = IDX_BITS'(pc_idx(SLICE_W'(upd_PC), IDX_BITS));
  assign u_tag = TAG_WIDTH'(pc_tag(SLICE_W'(upd_PC), IDX_BITS, TAG_WIDTH));

  // Lookup from registered state only; a same-cycle update is not bypassed.
  always_comb begin
    p_hit       = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
    pred_taken  = p_hit && line_cnt[p_idx][CNT_WIDTH-1];
    pred_target = pred_taken ? target_q[p_idx] : pred_PC + PC_WIDTH'(4);
  end

  // Resolution check against the prediction carried down the pipe.
  always_comb begin
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_target != upd_pred_target)));
    redirect_PC = upd_taken ? upd_target : upd_PC + PC_WIDTH'(4);
  end

  // Decide how the addressed line's counter moves; a flush suppresses training.
  always_comb begin
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    upd_en = upd_valid && !flush_req;
    tbl_wr = upd_en && upd_taken;
    act    = ACT_NONE;
    if (upd_en) begin
      if (u_hit) begin
        if (!upd_is_branch)  act = ACT_SET_MAX;
        else if (upd_taken)  act = ACT_INC;
        else                 act = ACT_DEC;
      end else if (upd_taken) begin
        act = upd_is_branch ? ACT_LOAD_WT : ACT_SET_MAX;
      end
    end
  end

  // Valid bits: flush clears all, a taken update allocates its line.
  always_comb begin
    valid_d = valid_q;
    if (flush_req) valid_d = '0;
    else if (tbl_wr) valid_d[u_idx] = 1'b1;
  end

  // Valid register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and target storage; a hit rewrites the same tag, so one path covers both cases.
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_line
    logic sel;
    assign sel = (u_idx == IDX_BITS'(i));

    bp_sat_counter #(
      .WIDTH   (CNT_WIDTH),
      .RST_VAL (CNT_WNT)
    ) u_dir_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (sel && (act == ACT_INC)),
      .dec_i      (sel && (act == ACT_DEC)),
      .set_max_i  (sel && (act == ACT_SET_MAX)),
      .load_i     (sel && (act == ACT_LOAD_WT)),
      .load_val_i (CNT_WT),
      .cnt_o      (line_cnt[i])
    );
  end

  bp_sat_counter #(
    .WIDTH   (PERF_WIDTH),
    .RST_VAL ('0)
  ) u_perf_br (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (upd_valid),
    .dec_i      (1'b0),
    .set_max_i  (1'b0),
    .load_i     (perf_clear),
    .load_val_i ('0),
    .cnt_o      (perf_branches)
  );

  bp_sat_counter #(
    .WIDTH   (PERF_WIDTH),
    .RST_VAL ('0)
  ) u_perf_mp (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (mispredict),
    .dec_i      (1'b0),
    .set_max_i  (1'b0),
    .load_i     (perf_clear),
    .load_val_i ('0),
    .cnt_o      (perf_mispredicts)
  );

endmodule
